mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the two-bit command interface driven by the access FSM. It consumes the FSM's `valid`/`rw` outputs, with an externally supplied address and write data. It performs a fixed-latency read or write on an internal word array and returns read data with a one-cycle `done` pulse. The block sits between the access FSM and the storage array, closing the request/response loop.

## Interface
Parameters:
- `ADDR_W`, 4, address width; array depth is 2^ADDR_W words
- `DATA_W`, 8, word width
- `ACC_CYCLES`, 3, cycles spent in ACCESS per command; legal range 1..15

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `valid`  in  1  command present (FSM Read/Write states)
- `rw`  in  1  command type when `valid`=1: 0 = read, 1 = write
- `addr`  in  ADDR_W  word address; sampled only at command accept
- `wdata`  in  DATA_W  write data; sampled only at command accept
- `rdata`  out  DATA_W  registered read data; holds until the next read completes
- `done`  out  1  one-cycle pulse marking command completion
- `busy`  out  1  high while a command is in progress (ACCESS state)

## Operation
- Reset is synchronous and active-high. With `rst`=1 at an edge:
  - state goes to IDLE and the counter is cleared
  - `rdata`=0, `done`=0, `busy`=0
  - every array word is cleared to 0
- States: IDLE, ACCESS, DONE, HOLD.
- IDLE:
  - if `valid`=1, latch `addr`, `wdata` and `rw` into command registers, load the counter with ACC_CYCLES-1, and go to ACCESS
  - otherwise stay in IDLE
- ACCESS:
  - `busy`=1; the counter decrements each cycle
  - inputs are ignored, including `valid` dropping; a command, once accepted, always completes
  - when the counter is 0:
    - write: the array word at the latched address takes the latched data at this edge
    - read: `rdata` takes the array word at the latched address at this edge
    - go to DONE
- DONE:
  - `done`=1 for exactly this cycle, `busy`=0
  - next state is HOLD
- HOLD: waits for the current command to be released.
  - `valid`=0: go to IDLE
  - `valid`=1 with `rw` different from the latched `rw`: this is a new command (FSM moved directly between Read and Write). Accept it exactly as IDLE does and go to ACCESS.
  - `valid`=1 with the same `rw`: stay in HOLD. The same command is never executed twice.
- A read of a word written earlier returns the written value. A read of an address never written since reset returns 0.
- A write does not change `rdata`.
- Address is not bounds-checked; all 2^ADDR_W values are valid.

## Timing
- Accept edge T is an edge where `valid`=1 is sampled in IDLE or in HOLD (with a new `rw`).
- `busy`=1 from T+1 through T+ACC_CYCLES.
- The array update or `rdata` update happens at edge T+ACC_CYCLES.
- `done`=1 during cycle T+ACC_CYCLES+1, i.e. `done` rises ACC_CYCLES+1 cycles after acceptance. `rdata` is already valid when `done` is high.
- Minimum spacing between accepts: ACC_CYCLES+2 cycles (accept → ACCESS → DONE → HOLD → accept).
- When ACC_CYCLES=1, ACCESS lasts one cycle.
- Reset mid-operation:
  - a write whose commit edge is not yet reached is discarded
  - `done` is not produced
  - outputs take their reset values on the next edge
- Reset has priority over every transition.
- `done` and `busy` are never high in the same cycle.

## Test plan
- Reset, then idle 5 cycles → `rdata`=0, `done`=0, `busy`=0. A read at addr 7 completes with `rdata`=0x00.
- Write 0xA5 to addr 3: `valid`=1, `rw`=1 for one cycle at T → `busy` high for 3 cycles, `done` at T+4. A following read of addr 3 gives `rdata`=0xA5 at its `done`.
- Hold `valid`=1, `rw`=0 for 20 cycles at addr 2 → exactly one `done` pulse, then HOLD with no further accesses.
- Write (`rw`=1) held, then switched directly to read (`rw`=0) without dropping `valid`, all at addr 9 with wdata 0x3C:
  - two `done` pulses, spaced ACC_CYCLES+2=5 cycles apart
  - final `rdata`=0x3C
- Write 0xFF to addr 15, then assert `rst` during the second ACCESS cycle:
  - no `done`
  - a subsequent read of addr 15 returns 0x00
- Address wrap/coverage: write a distinct value to each of the 16 addresses, then read all 16 back → every value matches.
- `addr` and `wdata` changed during ACCESS → stored data matches the values sampled at accept.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - command/response bundle between the access FSM and mem_responder
interface mem_responder_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              valid;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              done;
   logic              busy;

   modport master (output valid, rw, addr, wdata, input rdata, done, busy);
   modport slave  (input valid, rw, addr, wdata, output rdata, done, busy);
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word-array responder with done pulse and busy flag
module mem_responder #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int ACC_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus
);
   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              cmd_rw;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic              done_q;
   logic              busy_q;
   logic              accept;

   // HOLD only re-accepts when rw flips, so a held command never runs twice
   assign accept = bus.valid && ((state == IDLE) || (state == HOLD && bus.rw != cmd_rw));

   assign bus.rdata = rdata_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_rw    <= 1'b0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[ADDR_W'(i)] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            cmd_addr  <= bus.addr;
            cmd_wdata <= bus.wdata;
            cmd_rw    <= bus.rw;
            cnt       <= CNT_LOAD;
            busy_q    <= 1'b1;
            state     <= ACCESS;
         end else begin
            case (state)
               ACCESS: begin
                  if (cnt == '0) begin
                     if (cmd_rw) begin
                        mem[cmd_addr] <= cmd_wdata;
                     end else begin
                        rdata_q <= mem[cmd_addr];
                     end
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               DONE: state <= HOLD;
               HOLD: begin
                  if (!bus.valid) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with random traffic and a word-array model
module tb_mem_responder;
   localparam int ACC = 3;

   typedef struct {
      logic [7:0] rdata;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;

   exp_t       sb[$];
   logic [7:0] model [16];
   logic [7:0] last_rd;

   mem_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   mem_responder #(.ADDR_W(4), .DATA_W(8), .ACC_CYCLES(ACC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         checks++;
         if (bus.done && bus.busy) begin
            errors++;
            $display("FAIL done_busy_overlap cyc=%0d got done=1 busy=1 required not both", cyc);
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done cyc=%0d got done=1 required no pending command", cyc);
            end else begin
               e = sb.pop_front();
               checks += 3;
               if (bus.rdata !== e.rdata) begin
                  errors++;
                  $display("FAIL rdata cyc=%0d got=%02h required=%02h", cyc, bus.rdata, e.rdata);
               end
               if (cyc != e.cyc) begin
                  errors++;
                  $display("FAIL done_latency got cyc=%0d required cyc=%0d", cyc, e.cyc);
               end
               if (busy_cnt != ACC) begin
                  errors++;
                  $display("FAIL busy_len cyc=%0d got=%0d required=%0d", cyc, busy_cnt, ACC);
               end
            end
            busy_cnt = 0;
         end
      end
   end

   // Model: commands are serialized, so the result is known the moment a command is issued
   function automatic void model_cmd(input logic w, input logic [3:0] a, input logic [7:0] d, input int done_cyc);
      exp_t e;
      if (w) model[a] = d;
      else   last_rd  = model[a];
      e.rdata = last_rd;
      e.cyc   = done_cyc;
      sb.push_back(e);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      last_rd = 8'h00;
      sb.delete();
   endfunction

   task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%02h required=%02h", name, got, req);
      end
   endtask

   // Wait for all expectations to drain, drop valid, let the DUT return to IDLE
   task automatic wait_done();
      int k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(posedge clk);
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL done_timeout got pending=%0d required=0", sb.size());
         sb.delete();
      end
      #1 bus.valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1 with the DUT in IDLE; inputs are scrambled after accept
   task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d);
      bus.valid = 1'b1;
      bus.rw    = w;
      bus.addr  = a;
      bus.wdata = d;
      model_cmd(w, a, d, cyc + ACC + 1);
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
      bus.rw    = 1'($urandom);
      bus.addr  = 4'($urandom);
      bus.wdata = 8'($urandom);
      wait_done();
   endtask

   initial begin
      logic [7:0] base;
      int         c;
      bus.valid = 1'b0;
      bus.rw    = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_val("reset_rdata", bus.rdata, 8'h00);
      check_val("reset_done", {7'd0, bus.done}, 8'h00);
      check_val("reset_busy", {7'd0, bus.busy}, 8'h00);

      issue(1'b0, 4'd7, 8'h00);
      issue(1'b1, 4'd3, 8'hA5);
      issue(1'b0, 4'd3, 8'h00);

      // Held read: exactly one completion
      c = cyc;
      bus.valid = 1'b1; bus.rw = 1'b0; bus.addr = 4'd2;
      model_cmd(1'b0, 4'd2, 8'h00, c + ACC + 1);
      repeat (20) @(posedge clk);
      #1 bus.valid = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL held_read_done got pending=%0d required=0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;

      // Write held, then rw flipped to read without dropping valid
      c = cyc;
      bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = 4'd9; bus.wdata = 8'h3C;
      model_cmd(1'b1, 4'd9, 8'h3C, c + ACC + 1);
      model_cmd(1'b0, 4'd9, 8'h00, c + 2 * ACC + 3);
      @(posedge clk);
      #1 bus.rw = 1'b0;
      wait_done();
      check_val("switch_final_rdata", bus.rdata, 8'h3C);

      // Reset in the second ACCESS cycle of a write discards it
      bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = 4'd15; bus.wdata = 8'hFF;
      @(posedge clk);
      #1 bus.valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check_val("midop_reset_rdata", bus.rdata, 8'h00);
      check_val("midop_reset_busy", {7'd0, bus.busy}, 8'h00);
      check_val("midop_reset_done", {7'd0, bus.done}, 8'h00);
      @(posedge clk);
      #1;
      issue(1'b0, 4'd15, 8'h00);

      // Every address gets a distinct value, then all are read back
      base = 8'($urandom);
      for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), base + 8'(i * 37));
      for (int i = 0; i < 16; i++) issue(1'b0, 4'(i), 8'h00);

      for (int i = 0; i < 40; i++) issue(1'($urandom), 4'($urandom), 8'($urandom));

      repeat (4) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leftover_expect got pending=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout at cyc=%0d required bench completion", cyc);
      $fatal(1);
   end
endmodule
